// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/response bundle between the EX stage and the HI/LO multiply/divide unit.
// The master side belongs to EX and the slave side belongs to ex_muldiv.
interface ex_muldiv_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output req_valid, req_op, req_src1, req_src2, flush,
      input  req_ready, busy, done, hi, lo
   );

   modport slave (
      input  req_valid, req_op, req_src1, req_src2, flush,
      output req_ready, busy, done, hi, lo
   );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit that owns the architectural HI/LO registers.
// Defining MULDIV_FASTMUL_EN gives single-cycle multiplies; divides stay iterative.
module ex_muldiv (
   input logic        clk,
   input logic        reset,
   ex_muldiv_if.slave bus
);
   localparam logic [2:0] OpMthi = 3'b100;
   localparam logic [2:0] OpMtlo = 3'b101;

   typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;
   state_e state_q, state_d;

   logic [4:0]  cnt_q;
   logic        div_q, neg_q, rem_neg_q, div0_q;
   logic [31:0] opnd_q, src1_q;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d;
   logic        req_ready, busy;
   logic        accept, start_calc, signed_op;
   logic [31:0] mag1, mag2;
   logic [32:0] trial, sum;
   logic [63:0] prod;
   logic [31:0] quo, rem;

   assign accept    = bus.req_valid && req_ready && !bus.flush;
   assign signed_op = !bus.req_op[0];
   assign mag1      = (signed_op && bus.req_src1[31]) ? 32'd0 - bus.req_src1 : bus.req_src1;
   assign mag2      = (signed_op && bus.req_src2[31]) ? 32'd0 - bus.req_src2 : bus.req_src2;

`ifdef MULDIV_FASTMUL_EN
   logic        fast_mul;
   logic [63:0] ext1, ext2, fast_prod;

   assign start_calc = accept && (bus.req_op[2:1] == 2'b01);
   assign fast_mul   = accept && (bus.req_op[2:1] == 2'b00);
   // Sign- or zero-extension to 64 bits makes one truncated product serve both MULT and MULTU.
   assign ext1       = {(signed_op ? {32{bus.req_src1[31]}} : 32'd0), bus.req_src1};
   assign ext2       = {(signed_op ? {32{bus.req_src2[31]}} : 32'd0), bus.req_src2};
   assign fast_prod  = ext1 * ext2;
`else
   assign start_calc = accept && !bus.req_op[2];
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_calc) state_d = StCalc;
         StCalc:  if (cnt_q == 5'd31) state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (bus.flush) state_d = StIdle;
   end

   // Outputs decoded from state.
   always_comb begin
      req_ready = (state_q == StIdle);
      busy      = (state_q != StIdle);
   end

   // Multiply: acc holds {partial, multiplier}. Divide: acc holds {remainder, dividend/quotient}.
   always_comb begin
      trial = acc_q[63:31] - {1'b0, opnd_q};
      sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      if (div_q) begin
         acc_d = trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
      end else begin
         acc_d = {sum, acc_q[31:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         cnt_q     <= 5'd0;
         div_q     <= bus.req_op[1];
         opnd_q    <= bus.req_op[1] ? mag2 : mag1;
         acc_q     <= {32'd0, (bus.req_op[1] ? mag1 : mag2)};
         neg_q     <= signed_op && (bus.req_src1[31] ^ bus.req_src2[31]);
         rem_neg_q <= signed_op && bus.req_src1[31];
         div0_q    <= (bus.req_src2 == 32'd0);
         src1_q    <= bus.req_src1;
      end else if (state_q == StCalc) begin
         cnt_q <= cnt_q + 5'd1;
         acc_q <= acc_d;
      end
   end

   // Sign fix-up applied as the result is committed in FIN.
   always_comb begin
      prod = neg_q ? 64'd0 - acc_q : acc_q;
      quo  = neg_q ? 32'd0 - acc_q[31:0] : acc_q[31:0];
      rem  = rem_neg_q ? 32'd0 - acc_q[63:32] : acc_q[63:32];
   end

   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      if (accept && bus.req_op == OpMthi) begin
         hi_d   = bus.req_src1;
         done_d = 1'b1;
      end else if (accept && bus.req_op == OpMtlo) begin
         lo_d   = bus.req_src1;
         done_d = 1'b1;
`ifdef MULDIV_FASTMUL_EN
      end else if (fast_mul) begin
         {hi_d, lo_d} = fast_prod;
         done_d       = 1'b1;
`endif
      end else if (state_q == StFin && !bus.flush) begin
         done_d = 1'b1;
         if (!div_q) begin
            {hi_d, lo_d} = prod;
         end else if (div0_q) begin
            hi_d = src1_q;
            lo_d = 32'hFFFF_FFFF;
         end else begin
            hi_d = rem;
            lo_d = quo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         done_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.busy      = busy;
   assign bus.done      = done_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven bench for ex_muldiv with a HI/LO scoreboard and flush/reset sequences.
module tb_ex_muldiv;
   logic clk;
   logic reset;

   ex_muldiv_if bus ();

   ex_muldiv dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges after the accept edge before done becomes visible.
`ifdef MULDIV_FASTMUL_EN
   localparam int MulEdges = 0;
`else
   localparam int MulEdges = 33;
`endif
   localparam int DivEdges = 33;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] hi;
      logic [31:0] lo;
      int          edges;
   } vec_t;

   vec_t        vecs[14];
   logic [63:0] sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_hi, model_lo;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input int idx);
      int          cyc;
      logic        got;
      logic [63:0] exp;
      @(negedge clk);
      check($sformatf("ready_before[%0d]", idx), bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_op    = v.op;
      bus.req_src1  = v.s1;
      bus.req_src2  = v.s2;
      sb_q.push_back({v.hi, v.lo});
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check($sformatf("busy_after_accept[%0d]", idx), bus.busy, (v.edges != 0));
      cyc = 0;
      got = bus.done;
      while (!got && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         got = bus.done;
      end
      exp = sb_q.pop_front();
      if (!got) begin
         check($sformatf("done_timeout[%0d]", idx), 0, 1);
      end else begin
         check($sformatf("latency[%0d]", idx), cyc, v.edges);
         check($sformatf("hi[%0d]", idx), bus.hi, exp[63:32]);
         check($sformatf("lo[%0d]", idx), bus.lo, exp[31:0]);
         check($sformatf("ready_at_done[%0d]", idx), bus.req_ready, 1);
         model_hi = exp[63:32];
         model_lo = exp[31:0];
         @(posedge clk);
         #1;
         check($sformatf("done_one_cycle[%0d]", idx), bus.done, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vecs[0]  = '{op: 3'b010, s1: 32'hFFFF_FFF9, s2: 32'd2,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, edges: DivEdges};
      vecs[1]  = '{op: 3'b011, s1: 32'd100,       s2: 32'd0,         hi: 32'd100,       lo: 32'hFFFF_FFFF, edges: DivEdges};
      vecs[2]  = '{op: 3'b000, s1: 32'hFFFF_FFFF, s2: 32'hFFFF_FFFF, hi: 32'd0,         lo: 32'd1,         edges: MulEdges};
      vecs[3]  = '{op: 3'b001, s1: 32'hFFFF_FFFF, s2: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'd1,         edges: MulEdges};
      vecs[4]  = '{op: 3'b100, s1: 32'h1234_5678, s2: 32'd0,         hi: 32'h1234_5678, lo: 32'd1,         edges: 0};
      vecs[5]  = '{op: 3'b101, s1: 32'hCAFE_BABE, s2: 32'd7,         hi: 32'h1234_5678, lo: 32'hCAFE_BABE, edges: 0};
      vecs[6]  = '{op: 3'b010, s1: 32'h8000_0000, s2: 32'hFFFF_FFFF, hi: 32'd0,         lo: 32'h8000_0000, edges: DivEdges};
      vecs[7]  = '{op: 3'b010, s1: 32'd7,         s2: 32'hFFFF_FFFE, hi: 32'd1,         lo: 32'hFFFF_FFFD, edges: DivEdges};
      vecs[8]  = '{op: 3'b011, s1: 32'hFFFF_FFFF, s2: 32'd10,        hi: 32'd5,         lo: 32'h1999_9999, edges: DivEdges};
      vecs[9]  = '{op: 3'b000, s1: 32'h8000_0000, s2: 32'd2,         hi: 32'hFFFF_FFFF, lo: 32'd0,         edges: MulEdges};
      vecs[10] = '{op: 3'b001, s1: 32'h1234_5678, s2: 32'h10,        hi: 32'd1,         lo: 32'h2345_6780, edges: MulEdges};
      vecs[11] = '{op: 3'b010, s1: 32'hFFFF_FF9C, s2: 32'd0,         hi: 32'hFFFF_FF9C, lo: 32'hFFFF_FFFF, edges: DivEdges};
      vecs[12] = '{op: 3'b000, s1: 32'd7,         s2: 32'hFFFF_FFFD, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, edges: MulEdges};
      vecs[13] = '{op: 3'b010, s1: 32'hFFFF_FF9C, s2: 32'd7,         hi: 32'hFFFF_FFFE, lo: 32'hFFFF_FFF2, edges: DivEdges};

      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'b000;
      bus.req_src1  = 32'd0;
      bus.req_src2  = 32'd0;
      bus.flush     = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("reset_hi", bus.hi, 0);
      check("reset_lo", bus.lo, 0);
      check("reset_ready", bus.req_ready, 1);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      model_hi = 32'd0;
      model_lo = 32'd0;

      for (int i = 0; i < 14; i++) run_op(vecs[i], i);

      // Reserved opcode is swallowed without a done or HI/LO change.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b110;
      bus.req_src1  = 32'hA5A5_A5A5;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      n = 0;
      repeat (3) begin
         if (bus.done) n++;
         @(posedge clk);
         #1;
      end
      check("reserved_no_done", n, 0);
      check("reserved_ready", bus.req_ready, 1);
      check("reserved_hi", bus.hi, model_hi);
      check("reserved_lo", bus.lo, model_lo);

      // Flush ten cycles into a DIV, with a competing MTHI in the flush cycle.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b010;
      bus.req_src1  = 32'd1000;
      bus.req_src2  = 32'd3;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      check("calc_busy", bus.busy, 1);
      bus.flush     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b100;
      bus.req_src1  = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      check("flush_calc_ready", bus.req_ready, 1);
      check("flush_calc_busy", bus.busy, 0);
      n = 0;
      repeat (40) begin
         if (bus.done) n++;
         @(posedge clk);
         #1;
      end
      check("flush_calc_no_done", n, 0);
      check("flush_calc_hi", bus.hi, model_hi);
      check("flush_calc_lo", bus.lo, model_lo);

      // Flush landing on the FIN cycle suppresses the write.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b011;
      bus.req_src1  = 32'd100;
      bus.req_src2  = 32'd7;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (32) @(posedge clk);
      #1;
      check("fin_busy", bus.busy, 1);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush_fin_done", bus.done, 0);
      check("flush_fin_ready", bus.req_ready, 1);
      check("flush_fin_hi", bus.hi, model_hi);
      check("flush_fin_lo", bus.lo, model_lo);
      @(posedge clk);
      #1;
      check("flush_fin_no_late_done", bus.done, 0);

      // Flush in IDLE blocks a same-cycle MTLO.
      @(negedge clk);
      bus.flush     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b101;
      bus.req_src1  = 32'h0000_0055;
      @(posedge clk);
      #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      check("flush_idle_done", bus.done, 0);
      check("flush_idle_lo", bus.lo, model_lo);

      // Reset mid-operation discards it and clears HI/LO.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'b010;
      bus.req_src1  = 32'd50;
      bus.req_src2  = 32'd5;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_hi", bus.hi, 0);
      check("midreset_lo", bus.lo, 0);
      check("midreset_busy", bus.busy, 0);
      check("midreset_done", bus.done, 0);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) n++;
      end
      check("midreset_no_done", n, 0);
      check("midreset_ready", bus.req_ready, 1);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide responder serving the EX stage of the pipelined MIPS core. EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests over a valid/ready handshake. This block owns the architectural HI/LO registers, computes results over multiple cycles, and signals completion with a one-cycle `done` pulse. While `busy`, the pipeline stalls any instruction that reads or writes HI/LO.

## Interface
- No parameters. Datapath width is fixed at 32.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  EX presents a request this cycle.
- `req_ready`  out  1  high when the block can accept a request (state IDLE).
- `req_op`  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- `req_src1`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `req_src2`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  cancel any in-flight operation (exception/eret).
- `busy`  out  1  high in CALC and FIN.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- A request is accepted on an edge where `req_valid && req_ready && !flush`. Operands and op are latched at that edge.
- States:
  - IDLE: `req_ready`=1, `busy`=0.
  - CALC: 32 iterations, 5-bit counter 0..31.
  - FIN: sign fix-up and HI/LO write.
- Transitions:
  - Accept in IDLE, MULT/MULTU/DIV/DIVU → CALC, counter=0.
  - CALC with counter=31 → FIN.
  - FIN → IDLE; HI/LO written; `done`<=1.
- MTHI/MTLO are written at the accept edge. State stays IDLE. `done` pulses the next cycle.
- Reserved ops are accepted and ignored: no state change, no `done`.
- Multiply:
  - Shift-add on 32-bit magnitudes into a 64-bit product.
  - Signed MULT negates the product in FIN if operand signs differ.
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring division on magnitudes, 1 quotient bit per CALC cycle.
  - DIV: quotient is negated if signs differ; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - Edge cases: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divisor zero (DIV and DIVU): full latency; LO=0xFFFFFFFF, HI=req_src1.
- `flush`:
  - In any state, the next state is IDLE.
  - HI/LO are unchanged and no `done` is produced.
  - Flush beats a same-cycle request (not accepted) and a same-cycle FIN (no write).
- `reset` beats everything:
  - `hi`=0, `lo`=0, `done`=0, `busy`=0, state IDLE.
  - `req_ready`=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards the operation.

## Timing
- Accept edge E0 → CALC edges E1..E32 → FIN edge E33.
- After E33: `done`=1, new HI/LO visible, `req_ready`=1. A new request may be accepted at E34.
- Iterative ops have 33-cycle latency from the accept edge.
- MTHI/MTLO have 1-cycle latency.
- `done` is high for exactly one cycle per completed operation and never during reset.
- HI/LO change only at FIN edges, MTHI/MTLO accept edges, or reset.

## Configuration
- `MULDIV_FASTMUL_EN` defined:
  - MULT/MULTU compute a single-cycle 32×32 product.
  - HI/LO are written at the accept edge, state stays IDLE, and `done` pulses the next cycle (latency 1).
  - Divide is unchanged.
- `MULDIV_FASTMUL_EN` undefined: multiply uses the 33-cycle shift-add path above.
- Results are bit-identical in both builds.

## Test plan
- Reset, then idle: `hi`=`lo`=0, `req_ready`=1, `busy`=0, `done`=0.
- DIV 0xFFFFFFF9 (−7) / 2:
  - `done` 33 cycles after accept.
  - LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU 100/0: LO=0xFFFFFFFF, HI=100, same latency.
- MULT 0xFFFFFFFF × 0xFFFFFFFF:
  - HI=0, LO=1.
  - MULTU of the same operands gives HI=0xFFFFFFFE, LO=1.
  - Latency is 33 cycles, or 1 with `MULDIV_FASTMUL_EN`.
- MTHI 0x12345678: accept with `req_valid`=1 and `req_op`=100; `done` next cycle; HI=0x12345678, LO unchanged.
- DIV in flight, `flush` at cycle 10:
  - IDLE next cycle; no `done`; HI/LO keep their prior values.
  - A request presented in the flush cycle is not accepted.
